// File: rtl/dm_resp_pkg.sv
// Shared encodings and request record for the data-memory responder.
package dm_resp_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_WAIT = 2'd1,
    DMR_RESP = 2'd2
  } dmr_state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
  } dmr_req_t;

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering for loads/stores: enables, replicated write data, load extension.
// Purely combinational; misal also flags the reserved size code.
module dm_lane
  import dm_resp_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rext,
  output logic        misal
);

  logic [7:0]  lb;
  logic [15:0] lh;

  assign lb = rword[{addr, 3'b000} +: 8];
  assign lh = addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be    = 4'b0000;
    wword = wdata;
    rext  = '0;
    misal = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be    = 4'b0001 << addr;
        wword = {4{wdata[7:0]}};
        rext  = {{24{sgn & lb[7]}}, lb};
      end
      SIZE_HALF: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
        rext  = {{16{sgn & lh[15]}}, lh};
        misal = addr[0];
      end
      SIZE_WORD: begin
        be    = 4'b1111;
        rext  = rword;
        misal = (addr != 2'b00);
      end
      default: misal = 1'b1;
    endcase
  end

endmodule

// File: rtl/dm_resp.sv
// Data-memory responder: one request in flight, response WAIT_CYCLES+1 cycles after accept.
// req_ready drops while busy; the one-cycle response strobe has no backpressure.
module dm_resp
  import dm_resp_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int DEPTH_WORDS = 3072,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W   = ADDR_W - 2;
  localparam bit NO_WAIT = (WAIT_CYCLES == 0);

  dmr_state_t        state, state_nxt;
  logic [3:0]        cnt;
  dmr_req_t          lat_req, cur_req;
  logic [ADDR_W-1:0] lat_addr, cur_addr;
  logic [IDX_W-1:0]  cur_idx;
  logic              accept, commit, oor, err;
  logic [3:0]        be;
  logic [31:0]       wword, rext, rword;
  logic              misal;

  logic [31:0] mem [DEPTH_WORDS];

  // With no wait states the commit coincides with accept, so the live request is used.
  assign cur_req  = (state == DMR_IDLE) ? '{we: req_we, size: req_size, sgn: req_signed, wdata: req_wdata} : lat_req;
  assign cur_addr = (state == DMR_IDLE) ? req_addr : lat_addr;
  assign cur_idx  = cur_addr[ADDR_W-1:2];
  assign oor      = 32'(cur_idx) >= 32'(DEPTH_WORDS);
  assign err      = misal | oor;
  assign rword    = mem[cur_idx];

  assign accept = req_valid & req_ready;
  assign commit = (state == DMR_IDLE && accept && NO_WAIT) || (state == DMR_WAIT && cnt == 4'd1);

  dm_lane u_lane (
    .size  (cur_req.size),
    .addr  (cur_addr[1:0]),
    .sgn   (cur_req.sgn),
    .wdata (cur_req.wdata),
    .rword (rword),
    .be    (be),
    .wword (wword),
    .rext  (rext),
    .misal (misal)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= DMR_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      DMR_IDLE: if (accept) state_nxt = NO_WAIT ? DMR_RESP : DMR_WAIT;
      DMR_WAIT: if (cnt == 4'd1) state_nxt = DMR_RESP;
      DMR_RESP: state_nxt = DMR_IDLE;
      default:  state_nxt = DMR_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == DMR_IDLE);
    rsp_valid = (state == DMR_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst)                  cnt <= '0;
    else if (accept)           cnt <= 4'(WAIT_CYCLES);
    else if (state == DMR_WAIT) cnt <= cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lat_req  <= cur_req;
      lat_addr <= req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= err;
      rsp_rdata <= (err || cur_req.we) ? 32'd0 : rext;
    end
  end

  // Array has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && commit && cur_req.we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[cur_idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_resp.sv
// Directed bench for dm_resp: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_dm_resp;
  import dm_resp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_valid, a_ready, a_we, a_sgn, a_rsp_valid, a_err;
  logic [1:0]  a_size;
  logic [13:0] a_addr;
  logic [31:0] a_wdata, a_rdata;

  logic        b_valid, b_ready, b_we, b_sgn, b_rsp_valid, b_err;
  logic [1:0]  b_size;
  logic [13:0] b_addr;
  logic [31:0] b_wdata, b_rdata;

  dm_resp #(.ADDR_W(14), .DEPTH_WORDS(3072), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_size(a_size), .req_signed(a_sgn), .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err)
  );

  dm_resp #(.ADDR_W(14), .DEPTH_WORDS(3072), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_size(b_size), .req_signed(b_sgn), .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; lat counts edges from accept to the
  // edge that sees rsp_valid high (0 means no response within the budget).
  task automatic a_xfer(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [13:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    a_valid = 1'b1; a_we = we; a_size = size; a_sgn = sgn; a_addr = addr; a_wdata = wdata;
    n = 0;
    while (!a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) a_valid = 1'b0;
      if (a_rsp_valid) begin
        lat = i;
        break;
      end
    end
    rdata = a_rdata;
    err   = a_err;
  endtask

  task automatic a_do(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [13:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    a_xfer(we, size, sgn, addr, wdata, rd, er, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rdata"}, rd, exp_rdata);
    chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  vm10;
    logic [5:0]  rm6, vm6;
    logic [31:0] d_a, d_b;
    logic        prev_rdy;
    int          first_rdy;

    rst = 1'b0;
    a_valid = 0; a_we = 0; a_size = 0; a_sgn = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_size = 0; b_sgn = 0; b_addr = 0; b_wdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, a_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);
    chk("rst_ready_w0", {31'd0, b_ready}, 32'd1);
    rst = 1'b1;

    // Word round trip and latency
    a_do("st_w10", 1'b1, SIZE_WORD, 1'b0, 14'h0010, 32'h8BADF00D, 32'h0, 1'b0);
    a_do("ld_w10", 1'b0, SIZE_WORD, 1'b0, 14'h0010, 32'h0, 32'h8BADF00D, 1'b0);

    // Byte store and sub-word loads
    a_do("st_b13", 1'b1, SIZE_BYTE, 1'b0, 14'h0013, 32'hAAAAAA80, 32'h0, 1'b0);
    a_do("ld_bs13", 1'b0, SIZE_BYTE, 1'b1, 14'h0013, 32'h0, 32'hFFFFFF80, 1'b0);
    a_do("ld_bu13", 1'b0, SIZE_BYTE, 1'b0, 14'h0013, 32'h0, 32'h00000080, 1'b0);
    a_do("ld_w10b", 1'b0, SIZE_WORD, 1'b0, 14'h0010, 32'h0, 32'h80ADF00D, 1'b0);
    a_do("ld_hs12", 1'b0, SIZE_HALF, 1'b1, 14'h0012, 32'h0, 32'hFFFF80AD, 1'b0);
    a_do("ld_hu10", 1'b0, SIZE_HALF, 1'b0, 14'h0010, 32'h0, 32'h0000F00D, 1'b0);
    a_do("ld_bu11", 1'b0, SIZE_BYTE, 1'b0, 14'h0011, 32'h0, 32'h000000F0, 1'b0);

    // Error cases
    a_do("ld_h11_err", 1'b0, SIZE_HALF, 1'b0, 14'h0011, 32'h0, 32'h0, 1'b1);
    a_do("st_w12_err", 1'b1, SIZE_WORD, 1'b0, 14'h0012, 32'hDEADBEEF, 32'h0, 1'b1);
    a_do("ld_w10c", 1'b0, SIZE_WORD, 1'b0, 14'h0010, 32'h0, 32'h80ADF00D, 1'b0);
    a_do("ld_w3000_err", 1'b0, SIZE_WORD, 1'b0, 14'h3000, 32'h0, 32'h0, 1'b1);
    a_do("ld_rsvd_err", 1'b0, SIZE_RSVD, 1'b0, 14'h0010, 32'h0, 32'h0, 1'b1);

    // Last valid word plus a half store into its upper lanes
    a_do("st_w2ffc", 1'b1, SIZE_WORD, 1'b0, 14'h2FFC, 32'h01020304, 32'h0, 1'b0);
    a_do("st_h2ffe", 1'b1, SIZE_HALF, 1'b0, 14'h2FFE, 32'h5555BEEF, 32'h0, 1'b0);
    a_do("ld_w2ffc", 1'b0, SIZE_WORD, 1'b0, 14'h2FFC, 32'h0, 32'hBEEF0304, 1'b0);
    @(negedge clk);
    chk("hold_valid", {31'd0, a_rsp_valid}, 32'd0);
    chk("hold_rdata", a_rdata, 32'hBEEF0304);

    // Reset during WAIT abandons the store
    a_do("st_w20", 1'b1, SIZE_WORD, 1'b0, 14'h0020, 32'hCAFEBABE, 32'h0, 1'b0);
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b1; a_size = SIZE_WORD; a_sgn = 1'b0; a_addr = 14'h0020; a_wdata = 32'h12345678;
    chk("abort_ready_pre", {31'd0, a_ready}, 32'd1);
    vm10 = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vm10[i] = a_rsp_valid;
      if (i == 0) begin a_valid = 1'b0; rst = 1'b0; end
      if (i == 1) begin
        rst = 1'b1;
        chk("abort_ready", {31'd0, a_ready}, 32'd1);
        chk("abort_rdata", a_rdata, 32'd0);
      end
    end
    chk("abort_no_rsp", {22'd0, vm10}, 32'd0);
    a_do("ld_w20", 1'b0, SIZE_WORD, 1'b0, 14'h0020, 32'h0, 32'hCAFEBABE, 1'b0);

    // Second request during WAIT is ignored until req_ready returns
    @(negedge clk);
    a_valid = 1'b1; a_we = 1'b0; a_size = SIZE_WORD; a_sgn = 1'b0; a_addr = 14'h0010; a_wdata = 32'h0;
    vm10 = '0; d_a = '0; d_b = '0; prev_rdy = 1'b0; first_rdy = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vm10[i] = a_rsp_valid;
      if (i == 2) d_a = a_rdata;
      if (i == 6) d_b = a_rdata;
      if (a_ready && first_rdy < 0) first_rdy = i;
      if (i == 0) a_addr = 14'h0020;
      else if (prev_rdy && a_valid) a_valid = 1'b0;
      prev_rdy = a_ready;
    end
    chk("busy_rsp_mask", {22'd0, vm10}, 32'h044);
    chk("busy_rsp1", d_a, 32'h80ADF00D);
    chk("busy_rsp2", d_b, 32'hCAFEBABE);
    chk("busy_ready_at", 32'(first_rdy), 32'd3);

    // Zero-wait instance, request held continuously
    @(negedge clk);
    b_valid = 1'b1; b_we = 1'b1; b_size = SIZE_WORD; b_sgn = 1'b0; b_addr = 14'h0040; b_wdata = 32'h88112233;
    rm6 = '0; vm6 = '0; d_a = '0; d_b = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rm6[i] = b_ready;
      vm6[i] = b_rsp_valid;
      if (i == 0) begin
        chk("w0_st_rdata", b_rdata, 32'd0);
        chk("w0_st_err", {31'd0, b_err}, 32'd0);
      end
      if (i == 2) d_a = b_rdata;
      if (i == 4) d_b = b_rdata;
      if (i == 1) begin b_we = 1'b0; b_size = SIZE_WORD; end
      if (i == 3) begin b_size = SIZE_HALF; b_sgn = 1'b1; b_addr = 14'h0042; end
      if (i == 5) b_valid = 1'b0;
    end
    chk("w0_ready_mask", {26'd0, rm6}, 32'h2A);
    chk("w0_rsp_mask", {26'd0, vm6}, 32'h15);
    chk("w0_ld_word", d_a, 32'h88112233);
    chk("w0_ld_half", d_b, 32'hFFFF8811);
    @(negedge clk);
    chk("w0_idle_after", {31'd0, b_rsp_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
